// File: rtl/alu_share_arbiter.sv
// Two-port arbiter that time-shares one combinational ALU and registers each
// winner's result into a per-requester response slot, with a contention counter.

module alu_share_alu (
  input  logic [4:0]  i_ctrl,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_branch_op,
  output logic [31:0] o_result,
  output logic        o_branch
);
  logic signed [31:0] w_sa;
  logic signed [31:0] w_sb;
  logic [1:0]         w_class;
  logic [2:0]         w_funct3;
  logic               w_slt;
  logic               w_sltu;

  assign w_sa     = i_a;
  assign w_sb     = i_b;
  assign w_class  = i_ctrl[4:3];
  assign w_funct3 = i_ctrl[2:0];
  assign w_slt    = (w_sa < w_sb);
  assign w_sltu   = (i_a < i_b);

  // Class 00 is the base op set; class 01 swaps ADD->SUB and SRL->SRA.
  always_comb begin
    o_result = '0;
    case (w_class)
      2'b00, 2'b01: begin
        case (w_funct3)
          3'b000:  o_result = w_class[0] ? (i_a - i_b) : (i_a + i_b);
          3'b001:  o_result = i_a << i_b[4:0];
          3'b010:  o_result = {31'd0, w_slt};
          3'b011:  o_result = {31'd0, w_sltu};
          3'b100:  o_result = i_a ^ i_b;
          3'b101:  o_result = w_class[0] ? 32'(w_sa >>> i_b[4:0]) : (i_a >> i_b[4:0]);
          3'b110:  o_result = i_a | i_b;
          default: o_result = i_a & i_b;
        endcase
      end
      2'b11:   o_result = i_a;
      default: o_result = '0;
    endcase
  end

  always_comb begin
    o_branch = 1'b0;
    if (i_branch_op) begin
      case (w_funct3)
        3'b000:  o_branch = (i_a == i_b);
        3'b001:  o_branch = (i_a != i_b);
        3'b100:  o_branch = w_slt;
        3'b101:  o_branch = !w_slt;
        3'b110:  o_branch = w_sltu;
        3'b111:  o_branch = !w_sltu;
        default: o_branch = 1'b0;
      endcase
    end
  end
endmodule

module alu_share_arbiter #(
  parameter bit FIXED_PRIO = 1'b0,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [5:0]       req0_ctrl,
  input  logic [5:0]       req1_ctrl,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req0_b,
  input  logic [31:0]      req1_b,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  input  logic             rsp0_ready,
  input  logic             rsp1_ready,
  output logic [31:0]      rsp0_result,
  output logic [31:0]      rsp1_result,
  output logic             rsp0_branch,
  output logic             rsp1_branch,
  output logic [CNT_W-1:0] conflict_count
);
  logic             r_rsp0_valid, r_rsp1_valid;
  logic [31:0]      r_rsp0_result, r_rsp1_result;
  logic             r_rsp0_branch, r_rsp1_branch;
  logic [CNT_W-1:0] r_conflict;
  logic             r_prio;

  logic             w_elig0, w_elig1;
  logic             w_gnt0, w_gnt1;
  logic             w_acc0, w_acc1;
  logic [5:0]       w_ctrl;
  logic [31:0]      w_a, w_b;
  logic [31:0]      w_alu_result;
  logic             w_alu_branch;
  logic             w_unused_ctrl5;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // A slot counts as free when empty or being drained this very cycle.
  assign w_elig0 = req0_valid && (!r_rsp0_valid || rsp0_ready);
  assign w_elig1 = req1_valid && (!r_rsp1_valid || rsp1_ready);

  always_comb begin
    w_gnt0 = w_elig0;
    w_gnt1 = w_elig1;
    if (w_elig0 && w_elig1) begin
      w_gnt0 = FIXED_PRIO || !r_prio;
      w_gnt1 = !w_gnt0;
    end
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign w_acc0     = req0_valid && w_gnt0;
  assign w_acc1     = req1_valid && w_gnt1;

  // Requester 0 drives the shared ALU whenever requester 1 is not granted.
  assign w_ctrl         = w_gnt1 ? req1_ctrl : req0_ctrl;
  assign w_a            = w_gnt1 ? req1_a    : req0_a;
  assign w_b            = w_gnt1 ? req1_b    : req0_b;
  assign w_unused_ctrl5 = w_ctrl[5];

  alu_share_alu u_alu (
    .i_ctrl      (w_ctrl[4:0]),
    .i_a         (w_a),
    .i_b         (w_b),
    .i_branch_op (w_ctrl[4:3] == 2'b10),
    .o_result    (w_alu_result),
    .o_branch    (w_alu_branch)
  );

  // Response slots, round-robin pointer and contention counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp0_valid  <= 1'b0;
      r_rsp1_valid  <= 1'b0;
      r_rsp0_result <= '0;
      r_rsp1_result <= '0;
      r_rsp0_branch <= 1'b0;
      r_rsp1_branch <= 1'b0;
      r_conflict    <= '0;
      r_prio        <= 1'b0;
    end else begin
      if (w_acc0) begin
        r_rsp0_valid  <= 1'b1;
        r_rsp0_result <= w_alu_result;
        r_rsp0_branch <= w_alu_branch;
      end else if (rsp0_ready) begin
        r_rsp0_valid  <= 1'b0;
      end
      if (w_acc1) begin
        r_rsp1_valid  <= 1'b1;
        r_rsp1_result <= w_alu_result;
        r_rsp1_branch <= w_alu_branch;
      end else if (rsp1_ready) begin
        r_rsp1_valid  <= 1'b0;
      end
      if (w_acc0)
        r_prio <= 1'b1;
      else if (w_acc1)
        r_prio <= 1'b0;
      if (w_elig0 && w_elig1)
        r_conflict <= sat_inc(r_conflict);
    end
  end

  assign rsp0_valid     = r_rsp0_valid;
  assign rsp1_valid     = r_rsp1_valid;
  assign rsp0_result    = r_rsp0_result;
  assign rsp1_result    = r_rsp1_result;
  assign rsp0_branch    = r_rsp0_branch;
  assign rsp1_branch    = r_rsp1_branch;
  assign conflict_count = r_conflict;
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU instance between two requesters: port 0 is the main execute stage, port 1 is the secondary issue path (address-gen/CSR helper).
- Arbitrates requests using valid/ready handshakes, drives the ALU with the winner's operands, and registers the result into a per-requester response slot.
- Provides a saturating contention counter for performance monitoring.

Parameters:
- FIXED_PRIO, 0, 0 = round-robin arbitration; 1 = requester 0 always wins.
- CNT_W, 16, width of the contention counter.

Ports:
- clock  in  1  single core clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&&ready.
- req0_ctrl / req1_ctrl  in  6  ALU control word: [4:3] class, [2:0] funct3.
- req0_a / req1_a  in  32  operand A.
- req0_b / req1_b  in  32  operand B.
- rsp0_valid / rsp1_valid  out  1  registered result available.
- rsp0_ready / rsp1_ready  in  1  consumer takes the result.
- rsp0_result / rsp1_result  out  32  registered ALU result.
- rsp0_branch / rsp1_branch  out  1  registered branch-taken flag.
- conflict_count  out  CNT_W  cycles in which an eligible requester lost arbitration.

Behaviour:
- **Reset.** While reset_n is low, asynchronously force:
  - rsp*_valid=0, rsp*_result=0, rsp*_branch=0
  - conflict_count=0
  - round-robin pointer prio=0 (requester 0 favoured)
  - Reset asserted mid-transaction discards any held response without handshake.
- **Slot free.** free_i = !rsp_i_valid || rsp_i_ready. A requester may accept while its slot drains in the same cycle.
- **Eligibility.** elig_i = req_i_valid && free_i.
- **Grant (combinational).**
  - Only one requester is eligible: it wins.
  - Both eligible, FIXED_PRIO=1: requester 0 wins.
  - Both eligible, FIXED_PRIO=0: requester indexed by prio wins.
  - At most one grant per cycle.
- **Ready.** req_i_ready = grant_i. Ready may depend on both valids and on rsp_i_ready. Requesters must not make valid depend on ready. No combinational path from req_ready back to req_valid.
- **ALU drive.** ctrl, a and b are muxed from the granted requester. With no grant, drive requester 0's inputs; results are unused.
  - ALU input branch_op is tied to (ctrl[4:3]==2'b10).
- **Accept (valid&&ready for requester i).** On that edge:
  - rsp_i_result <= ALU result
  - rsp_i_branch <= ALU branch flag
  - rsp_i_valid <= 1
  - Latency is exactly 1 cycle from accept to rsp_i_valid.
- **Response hold.** Result and branch stay stable while rsp_i_valid && !rsp_i_ready.
- **Response clear.**
  - rsp_i_valid <= 0 on rsp_i_ready with no new accept for i.
  - Simultaneous drain and accept keeps rsp_i_valid=1 with the new data.
- **Round-robin update.** After an accept by i, prio <= 1-i. With no accept, prio holds. In FIXED_PRIO=1 mode prio is ignored but still maintained.
- **Contention counter.** Increments by 1 on any cycle with elig_0 && elig_1 (the loser counts). It saturates at all-ones and never wraps.
- **Independence.** A stalled response slot (rsp_ready low) blocks only its own requester. The other requester continues to get full throughput.
- **Inputs.** Request inputs are sampled only on the accept edge. Values are don't-care otherwise.

Test Plan:
- **Reset values.** Assert reset_n=0 mid-run with rsp0_valid=1 → all outputs 0 immediately. After release, req1 alone with ctrl=6'b000000, a=5, b=7 → req1_ready=1; next cycle rsp1_valid=1, rsp1_result=12.
- **Round-robin and counter.**
  - Setup: FIXED_PRIO=0, both valid every cycle, rsp readies held high.
  - Requests: req0 SUB (6'b001000, a=10, b=3); req1 passthrough (6'b011000, a=0x1234).
  - Expect: grants alternate 0,1,0,1; rsp0_result=7; rsp1_result=0x1234; conflict_count increments every cycle.
- **Fixed priority.** FIXED_PRIO=1, both valid for 4 cycles → req0 granted every cycle, req1_ready=0 throughout, conflict_count=4.
- **Backpressure.**
  - Stimulus: req0 ADD a=1, b=1 accepted; hold rsp0_ready=0 for 3 cycles while req0_valid stays high.
  - Expect: rsp0_result stable at 2, req0_ready=0, req1 still granted every cycle. Then raise rsp0_ready → req0 accepted the same cycle and rsp0_valid stays 1 with the new result.
- **Branch path.** req0 BLT (6'b010100) a=0xFFFFFFFF, b=1 → rsp0_branch=1, rsp0_result=0. Same with BLTU (6'b010110) → rsp0_branch=0.
- **Counter saturation.** CNT_W=4, 20 contended cycles → conflict_count stops at 4'hF.
